// File: rtl/arith_dispatch_if.sv
// -----------------------------------------------------------------------------
// arith_dispatch_if
//   Command and response handshake bundle for arith_dispatch.
//
//   Command channel (source -> dispatcher):
//     cmd_valid, cmd_op (0 = add, 1 = mul), cmd_a, cmd_b, cmd_tag
//     cmd_ready (dispatcher -> source)
//   Response channel (dispatcher -> source):
//     rsp_valid, rsp_data, rsp_op, rsp_tag
//     rsp_ready (source -> dispatcher)
//
//   master : the command source / response consumer
//   slave  : the dispatcher
// -----------------------------------------------------------------------------
interface arith_dispatch_if #(
    parameter int TAG_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_op;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_tag
    );
endinterface

// File: rtl/arith_dispatch.sv
// -----------------------------------------------------------------------------
// arith_dispatch
//   Initiator for a registered 4-bit adder and a registered 4-bit multiplier.
//   Accepts tagged commands, drives registered operands onto the addressed
//   unit, tracks each operation through a fixed-latency in-flight pipe,
//   captures the unit result into a result FIFO and returns it in command
//   order with its op and tag.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     bus        command / response handshakes (slave side)
//     add_in1/2  adder operands (registered)
//     add_out    adder result (5 bits)
//     mul_in1/2  multiplier operands (registered)
//     mul_out    multiplier result (8 bits)
//     issued_cnt accepted-command counter, wraps 255 -> 0
//
//   Flow control is credit based: a command is only accepted when the FIFO
//   plus everything still in flight fits in DEPTH entries, so a result
//   arriving from a unit always has a free slot.
// -----------------------------------------------------------------------------
module arith_dispatch #(
    parameter int DEPTH    = 4,
    parameter int UNIT_LAT = 2,
    parameter int TAG_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    arith_dispatch_if.slave     bus,
    output logic [3:0]          add_in1,
    output logic [3:0]          add_in2,
    input  logic [4:0]          add_out,
    output logic [3:0]          mul_in1,
    output logic [3:0]          mul_in2,
    input  logic [7:0]          mul_out,
    output logic [7:0]          issued_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    // Occupancy can reach DEPTH + UNIT_LAT in principle; size for that.
    localparam int OCC_W = $clog2(DEPTH + UNIT_LAT + 1);

    typedef struct packed {
        logic             vld;
        logic             op;
        logic [TAG_W-1:0] tag;
    } pipe_entry_t;

    typedef struct packed {
        logic [7:0]       data;
        logic             op;
        logic [TAG_W-1:0] tag;
    } fifo_entry_t;

    pipe_entry_t pipe [UNIT_LAT];
    fifo_entry_t mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;

    logic             accept;
    logic             push;
    logic             pop;
    logic             rsp_valid_int;
    logic [OCC_W-1:0] occupancy;
    pipe_entry_t      head;
    fifo_entry_t      wr_entry;

    // -------------------------------------------------------------------------
    // Handshake decode and credit
    // -------------------------------------------------------------------------
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign head          = pipe[UNIT_LAT-1];
    assign push          = head.vld;
    assign rsp_valid_int = (fifo_count != '0);
    assign pop           = rsp_valid_int & bus.rsp_ready;

    // Occupancy is built purely from registered state, so rsp_ready never
    // reaches cmd_ready combinationally.
    always_comb begin
        // NOTE: assign every always_comb output a default before any branch or loop; a path that skips the assignment infers a latch.
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < UNIT_LAT; i++) begin
            occupancy = occupancy + OCC_W'(pipe[i].vld);
        end
    end

    assign bus.cmd_ready = (occupancy < OCC_W'(DEPTH));

    // -------------------------------------------------------------------------
    // Operand registers and accepted-command counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_in1    <= '0;
            add_in2    <= '0;
            mul_in1    <= '0;
            mul_in2    <= '0;
            issued_cnt <= '0;
        end else if (accept) begin
            if (bus.cmd_op) begin
                mul_in1 <= bus.cmd_a;
                mul_in2 <= bus.cmd_b;
            end else begin
                add_in1 <= bus.cmd_a;
                add_in2 <= bus.cmd_b;
            end
            issued_cnt <= issued_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // In-flight pipe: an entry reaches the head on the edge before the unit
    // result is ready, so the FIFO captures the result on the following edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < UNIT_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: accept, op: bus.cmd_op, tag: bus.cmd_tag};
            for (int i = 1; i < UNIT_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO
    // -------------------------------------------------------------------------
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = head.op ? mul_out : {3'b000, add_out};
        wr_entry.op   = head.op;
        wr_entry.tag  = head.tag;
    end

    // NOTE: the storage array is not reset; only pointers and count are, and the outputs are gated by rsp_valid so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push into a full FIFO cannot happen: the credit check reserved
            // a slot for every in-flight operation at accept time.
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Response outputs: head of FIFO, forced to zero when empty
    // -------------------------------------------------------------------------
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_data  = rsp_valid_int ? mem[rd_ptr].data : '0;
    assign bus.rsp_op    = rsp_valid_int ? mem[rd_ptr].op   : 1'b0;
    assign bus.rsp_tag   = rsp_valid_int ? mem[rd_ptr].tag  : '0;

endmodule

// File: tb/tb_arith_dispatch.sv
// -----------------------------------------------------------------------------
// tb_arith_dispatch
//   Directed bench for arith_dispatch. Registered adder/multiplier models sit
//   on the unit buses. Stimulus pushes the hand-computed expected response
//   into a queue; an independent monitor pops and compares on every response
//   handshake and checks response stability under backpressure.
// -----------------------------------------------------------------------------
module tb_arith_dispatch;

    localparam int DEPTH    = 4;
    localparam int UNIT_LAT = 2;
    localparam int TAG_W    = 3;
    localparam int EXP_LAT  = UNIT_LAT + 1;

    typedef struct {
        logic [7:0]       data;
        logic             op;
        logic [TAG_W-1:0] tag;
        int               acc_edge;
        bit               lat_chk;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] add_in1, add_in2, mul_in1, mul_in2;
    logic [4:0] add_out;
    logic [7:0] mul_out;
    logic [7:0] issued_cnt;

    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   exp_issued = 0;
    bit   lat_exact  = 0;
    exp_t q[$];

    arith_dispatch_if #(.TAG_W(TAG_W)) bus ();

    arith_dispatch #(
        .DEPTH   (DEPTH),
        .UNIT_LAT(UNIT_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_out   (add_out),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .issued_cnt(issued_cnt)
    );

    // Registered arithmetic units.
    always @(posedge clk) begin
        add_out <= {1'b0, add_in1} + {1'b0, add_in2};
        mul_out <= {4'b0, mul_in1} * {4'b0, mul_in2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one command; returns after the accepting edge with cmd_valid
    // still high so a following issue() runs back-to-back.
    task automatic issue(input logic op, input logic [3:0] a, input logic [3:0] b,
                         input logic [TAG_W-1:0] tag, input logic [7:0] exp_data,
                         output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: cmd_ready stayed 0, expected 1 within 200 cycles");
            bus.cmd_valid = 1'b0;
            return;
        end
        e.data     = exp_data;
        e.op       = op;
        e.tag      = tag;
        e.acc_edge = cyc + 1;
        e.lat_chk  = lat_exact;
        q.push_back(e);
        exp_issued++;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((q.size() != 0 || bus.rsp_valid) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0 || bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin : monitor
        exp_t       e;
        bit         hold_vld = 0;
        logic [7:0] h_data;
        logic       h_op;
        logic [TAG_W-1:0] h_tag;
        forever begin
            @(negedge clk);
            #4;
            if (!rst || !bus.rsp_valid) begin
                hold_vld = 0;
            end else begin
                if (hold_vld) begin
                    check("hold_data", 32'(bus.rsp_data), 32'(h_data));
                    check("hold_op",   32'(bus.rsp_op),   32'(h_op));
                    check("hold_tag",  32'(bus.rsp_tag),  32'(h_tag));
                end
                if (bus.rsp_ready) begin
                    hold_vld = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got data 0x%0h tag %0d, expected no response",
                                 bus.rsp_data, bus.rsp_tag);
                    end else begin
                        e = q.pop_front();
                        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                        check("rsp_op",   32'(bus.rsp_op),   32'(e.op));
                        check("rsp_tag",  32'(bus.rsp_tag),  32'(e.tag));
                        if (e.lat_chk) begin
                            check("latency", 32'(cyc + 1 - e.acc_edge), 32'(EXP_LAT));
                        end
                    end
                end else begin
                    hold_vld = 1;
                    h_data   = bus.rsp_data;
                    h_op     = bus.rsp_op;
                    h_tag    = bus.rsp_tag;
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        logic [7:0] v;

        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        check("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",   32'(bus.rsp_data),  32'd0);
        check("rst_rsp_op",     32'(bus.rsp_op),    32'd0);
        check("rst_rsp_tag",    32'(bus.rsp_tag),   32'd0);
        check("rst_issued_cnt", 32'(issued_cnt),    32'd0);
        check("rst_operands",   {16'd0, add_in1, add_in2, mul_in1, mul_in2}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // ---- Single add 15+15, tag 1 ----
        bus.rsp_ready = 1'b1;
        lat_exact     = 1;
        issue(1'b0, 4'hF, 4'hF, 3'd1, 8'h1E, waited);
        idle();
        drain();
        check("issued_after_add", 32'(issued_cnt), 32'd1);

        // ---- Single mul 15*15, tag 5 ----
        issue(1'b1, 4'hF, 4'hF, 3'd5, 8'hE1, waited);
        idle();
        drain();
        check("issued_after_mul", 32'(issued_cnt), 32'd2);

        // ---- Back-to-back stream; exact latency means consecutive responses ----
        issue(1'b0, 4'd3,  4'd4, 3'd0, 8'd7,  waited); check("b2b_ready0", 32'(waited), 32'd0);
        issue(1'b1, 4'd3,  4'd4, 3'd1, 8'd12, waited); check("b2b_ready1", 32'(waited), 32'd0);
        issue(1'b0, 4'd0,  4'd0, 3'd2, 8'd0,  waited); check("b2b_ready2", 32'(waited), 32'd0);
        issue(1'b1, 4'd15, 4'd0, 3'd3, 8'd0,  waited); check("b2b_ready3", 32'(waited), 32'd0);
        idle();
        drain();
        check("issued_after_b2b", 32'(issued_cnt), 32'd6);

        // ---- Backpressure: only DEPTH commands fit ----
        lat_exact     = 0;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd1, 4'd2, 3'd2, 8'h03, waited);
        issue(1'b1, 4'd2, 4'd3, 3'd3, 8'h06, waited);
        issue(1'b0, 4'd8, 4'd8, 3'd4, 8'h10, waited);
        issue(1'b1, 4'd4, 4'd5, 3'd6, 8'h14, waited);
        @(negedge clk);
        bus.cmd_op  = 1'b0;
        bus.cmd_a   = 4'd9;
        bus.cmd_b   = 4'd9;
        bus.cmd_tag = 3'd7;
        for (int k = 0; k < 6; k++) begin
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_issued",    32'(issued_cnt),    32'(8'(exp_issued)));
            @(negedge clk);
        end
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        issue(1'b0, 4'd9, 4'd9, 3'd7, 8'h12, waited);
        issue(1'b1, 4'd3, 4'd3, 3'd0, 8'h09, waited);
        idle();
        drain();
        check("issued_after_bp", 32'(issued_cnt), 32'(8'(exp_issued)));

        // ---- Reset with 2 results buffered and 1 in flight ----
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd1, 4'd1, 3'd1, 8'h02, waited);
        issue(1'b0, 4'd2, 4'd2, 3'd2, 8'h04, waited);
        issue(1'b0, 4'd3, 4'd3, 3'd3, 8'h06, waited);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_issued = 0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_issued",    32'(issued_cnt),    32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // ---- 256 accepted adds: counter wrap, tags modulo 2^TAG_W ----
        lat_exact = 1;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            issue(1'b0, v[3:0], v[7:4], v[TAG_W-1:0], 8'(v[3:0]) + 8'(v[7:4]), waited);
        end
        idle();
        check("issued_wrap", 32'(issued_cnt), 32'd0);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arith_dispatch.md
Name: arith_dispatch

Overview:
- Initiator for the registered 4-bit adder and 4-bit multiplier units.
- Accepts operation commands over a valid/ready handshake and drives operands onto the add and mul unit input buses.
- Tracks in-flight operations against the fixed unit latency, captures unit results into a result FIFO, and returns tagged responses over a second valid/ready handshake.
- Sits between a command source (sequencer/CPU-side logic) and the arithmetic units.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >= 2).
- UNIT_LAT, 2, cycles from the command-accept edge to the edge on which the unit result is captured (1 operand register + 1 unit register).
- TAG_W, 3, command/response tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  1  0 = add, 1 = mul.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_tag  in  TAG_W  opaque tag returned with the result.
- add_in1, add_in2  out  4  adder operands (registered).
- add_out  in  5  adder result.
- mul_in1, mul_in2  out  4  multiplier operands (registered).
- mul_out  in  8  multiplier result.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge.
- rsp_data  out  8  result; add results zero-extended from 5 bits.
- rsp_op  out  1  op of the returned result.
- rsp_tag  out  TAG_W  tag of the returned result.
- issued_cnt  out  8  accepted-command counter, wraps 255 -> 0.

Behaviour:
- Reset (rst = 0, asynchronous): all operand outputs = 0, rsp_valid = 0, rsp_data/rsp_op/rsp_tag = 0, issued_cnt = 0, FIFO empty, in-flight pipe cleared.
  - cmd_ready evaluates to 1 immediately after reset deasserts.
- Accept edge (cycle 0):
  - The addressed unit's operand registers load cmd_a/cmd_b.
  - The other unit's operands hold their previous values; operands also hold when idle.
  - {op, tag, valid} enters an in-flight shift pipe of length UNIT_LAT.
- Cycle UNIT_LAT: the pipe head is valid. On that edge the FIFO writes data = op ? mul_out : {3'b0, add_out}, plus op and tag.
- Throughput: one command per cycle; back-to-back adds and muls interleave freely. Results return in command order.
- Latency: rsp_valid rises no earlier than UNIT_LAT + 1 edges after accept. It is visible the cycle after the FIFO write (FIFO not fall-through).
- Credit rule:
  - cmd_ready = (fifo_count + inflight_count) < DEPTH, combinational from registered state.
  - A write can therefore never overflow the FIFO; no result is ever dropped.
  - Pop on the same edge does not feed back to cmd_ready in that cycle (no combinational rsp_ready -> cmd_ready path).
- FIFO:
  - Read and write pointers of log2(DEPTH) bits that wrap; count of log2(DEPTH)+1 bits.
  - Simultaneous push and pop with count = DEPTH: impossible by credit. With count = 0: pop ignored (rsp_valid = 0), push proceeds.
  - Simultaneous push and pop with 0 < count: count unchanged, both pointers advance.
- Response hold: rsp_data, rsp_op and rsp_tag are stable while rsp_valid = 1 and rsp_ready = 0.
- Counter: issued_cnt increments on each accepted command; 8-bit wrap.
- Reset mid-operation: in-flight and buffered results are discarded; no response for them ever appears after reset.
- Unit arithmetic is external; this block performs no arithmetic on results beyond the zero-extension.

Test Plan:
- Reset then single add a=4'hF, b=4'hF, tag=1, rsp_ready=1:
  - rsp_valid rises 3 edges after accept.
  - rsp_data = 8'h1E, rsp_op = 0, rsp_tag = 1; issued_cnt = 1.
- Single mul a=4'hF, b=4'hF, tag=5: rsp_data = 8'hE1, rsp_op = 1, rsp_tag = 5.
- Back-to-back stream add(3,4), mul(3,4), add(0,0), mul(15,0) with rsp_ready=1:
  - responses in order 7, 12, 0, 0 on consecutive cycles.
  - cmd_ready stays 1 throughout.
- Backpressure, rsp_ready=0, 6 commands offered:
  - exactly DEPTH = 4 accepted; cmd_ready = 0 thereafter; rsp fields stable.
  - Raising rsp_ready drains 4 results in order; cmd_ready returns, and the remaining 2 complete.
- Reset asserted for 1 cycle with 2 results buffered and 1 in flight: rsp_valid = 0 after reset, no stale response ever appears, issued_cnt = 0.
- 256 accepted adds: issued_cnt wraps to 0; all 256 responses are returned with correct tags modulo 2^TAG_W.
